// File: rtl/mux_scan_pkg.sv
// Shared types and default sizing for the mux scan sequencer.
// Latency: n/a (declarations only). Backpressure: n/a.
// Counter width helper keeps the settle timer sized from SETTLE_CYCLES.
package mux_scan_pkg;

  localparam int DEF_NUM_CH        = 16;
  localparam int DEF_SEL_W         = 4;
  localparam int DEF_SETTLE_CYCLES = 2;

  function automatic int cnt_width(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/scan_settle_timer.sv
// Loadable settle down-counter; zero flags the edge on which the count hits 0.
// Latency: load/dec take effect on the next edge. Backpressure: none.
// clear has priority over load, load over dec.
module scan_settle_timer
  import mux_scan_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = dec && (count == CNT_W'(1));

endmodule

// File: rtl/mux_scan_sequencer.sv
// Walks select over every mux channel, settles, samples, rebuilds the word (optional SCAN_PARITY_EN adds parity).
// Latency: done at NUM_CH*(SETTLE_CYCLES+1) edges after the start edge.
// Backpressure: none; start ignored while busy, abort cancels without done.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int SEL_W         = DEF_SEL_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              mux_out,
  output logic [SEL_W-1:0]  select,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] sample_word
`ifdef SCAN_PARITY_EN
  ,
  output logic              parity
`endif
);

  localparam int                 CNT_W    = cnt_width(SETTLE_CYCLES);
  localparam logic [SEL_W-1:0]   LAST_SEL = SEL_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0]   RELOAD   = CNT_W'(SETTLE_CYCLES);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("mux_scan_sequencer: SETTLE_CYCLES must be >= 1");
  end
  if (NUM_CH != (1 << SEL_W)) begin : g_bad_ch
    $error("mux_scan_sequencer: NUM_CH must equal 2**SEL_W");
  end

  scan_state_t       state;
  logic [NUM_CH-1:0] shadow;
  logic [NUM_CH-1:0] new_word;
  logic              last_ch;
  logic              t_load;
  logic              t_clear;
  logic              t_dec;
  logic              t_zero;

  assign last_ch  = (select == LAST_SEL);
  assign new_word = {mux_out, shadow[NUM_CH-2:0]};

  // Timer control mirrors the state the FSM is in during this cycle.
  always_comb begin
    t_load  = 1'b0;
    t_clear = 1'b0;
    t_dec   = 1'b0;
    case (state)
      IDLE:    t_load = start;
      SETTLE:  if (abort) t_clear = 1'b1; else t_dec = 1'b1;
      SAMPLE:  if (abort) t_clear = 1'b1; else t_load = !last_ch;
      default: t_clear = 1'b1;
    endcase
  end

  scan_settle_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .clear    (t_clear),
    .dec      (t_dec),
    .load_val (RELOAD),
    .zero     (t_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      select      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sample_word <= '0;
      shadow      <= '0;
`ifdef SCAN_PARITY_EN
      parity      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= SETTLE;
            select <= '0;
            busy   <= 1'b1;
          end
        end
        SETTLE: begin
          if (abort) begin
            state  <= IDLE;
            select <= '0;
            busy   <= 1'b0;
            shadow <= '0;
          end else if (t_zero) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (abort) begin
            state  <= IDLE;
            select <= '0;
            busy   <= 1'b0;
            shadow <= '0;
          end else begin
            shadow[select] <= mux_out;
            if (last_ch) begin
              sample_word <= new_word;
`ifdef SCAN_PARITY_EN
              parity      <= ^new_word;
`endif
              done        <= 1'b1;
              busy        <= 1'b0;
              select      <= '0;
              state       <= IDLE;
            end else begin
              select <= select + SEL_W'(1);
              state  <= SETTLE;
            end
          end
        end
        default: begin
          state  <= IDLE;
          select <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: models the 16:1 mux (combinational or registered) and
// predicts select/busy/done/word from the scan timing arithmetic.
module tb_mux_scan_sequencer;

  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;
  localparam int SC     = 2;
  localparam int TOTAL  = NUM_CH * (SC + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic              mux_out;
  logic [SEL_W-1:0]  select;
  logic              busy;
  logic              done;
  logic [NUM_CH-1:0] sample_word;
`ifdef SCAN_PARITY_EN
  logic              parity;
`endif

  logic [NUM_CH-1:0] data;
  logic              mux_q;
  bit                reg_mode;
  logic [NUM_CH-1:0] exp_word;
  int                tests = 0;
  int                fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mux_q <= data[select];
  assign mux_out = reg_mode ? mux_q : data[select];

  mux_scan_sequencer #(
    .NUM_CH        (NUM_CH),
    .SEL_W         (SEL_W),
    .SETTLE_CYCLES (SC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .mux_out     (mux_out),
    .select      (select),
    .busy        (busy),
    .done        (done),
    .sample_word (sample_word)
`ifdef SCAN_PARITY_EN
    ,
    .parity      (parity)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int exp_sel, input bit exp_busy, input bit exp_done);
    chk({tag, "_select"}, 32'(select), 32'(exp_sel));
    chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_word"}, 32'(sample_word), 32'(exp_word));
`ifdef SCAN_PARITY_EN
    chk({tag, "_parity"}, 32'(parity), 32'(^exp_word));
`endif
  endtask

  // Start edge k is the next posedge. After edge k+n, select = n/(SC+1) until
  // the completion edge k+TOTAL. abort_n / rst_at pick the cycle n to interfere.
  task automatic do_scan(input logic [NUM_CH-1:0] d, input bit keep, input int abort_n, input int rst_at);
    data  = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) start = 1'b0;
    for (int n = 0; n <= TOTAL; n++) begin
      @(negedge clk);
      if (n == TOTAL) begin
        exp_word = d;
        check_outputs("scan_end", 0, 1'b0, 1'b1);
      end else begin
        check_outputs("scan", n / (SC + 1), 1'b1, 1'b0);
      end
      if (n == abort_n) begin
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        for (int m = 0; m < TOTAL + 4; m++) begin
          @(negedge clk);
          check_outputs("abort", 0, 1'b0, 1'b0);
        end
        return;
      end
      if (n == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        exp_word = '0;
        check_outputs("async_rst", 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    if (!keep) begin
      @(negedge clk);
      check_outputs("after_done", 0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    data     = 16'hA5C3;
    reg_mode = 1'b0;
    exp_word = '0;
    #3;
    check_outputs("reset", 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle with no start; abort in IDLE must do nothing.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_outputs("idle", 0, 1'b0, 1'b0);
      abort = (i == 5 || i == 6);
    end
    abort = 1'b0;
    @(negedge clk);

    do_scan(16'hA5C3, 1'b0, -1, -1);
    // start held through the scan: one scan, then the next starts during done.
    do_scan(16'h0001, 1'b1, -1, -1);
    do_scan(16'($urandom), 1'b0, -1, -1);

    do_scan(16'hA5C3, 1'b0, -1, -1);
    do_scan(16'h5A5A, 1'b0, 7 * (SC + 1) + int'($urandom_range(0, SC)), -1);
    do_scan(16'h5A5A, 1'b0, 7 * (SC + 1) + SC, -1);

    do_scan(16'($urandom), 1'b0, -1, 10 * (SC + 1) + 1);
    do_scan(16'($urandom), 1'b0, -1, -1);

    reg_mode = 1'b1;
    @(negedge clk);
    do_scan(16'hA5C3, 1'b0, -1, -1);
    for (int i = 0; i < 4; i++) begin
      reg_mode = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      do_scan(16'($urandom), 1'b0, -1, -1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream controller for the 16:1 bit-select mux (`data[15:0]`, `select[3:0]` → `out`).
- On a `start` request it walks `select` through all 16 channels, waits a programmable settle time on each, and samples the mux output bit.
- It rebuilds the full 16-bit word and presents it with a one-cycle `done` pulse.
- Used to serialise a wide bus through one mux output and back, e.g. for scan/readback.

Parameters:
- NUM_CH, 16, number of mux channels scanned; must equal 2**SEL_W.
- SEL_W, 4, select width driven to the mux.
- SETTLE_CYCLES, 2, cycles held on each channel before sampling; must be ≥1 (elaboration error otherwise).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a full scan; honoured only in IDLE.
- abort  input  1  synchronous cancel of an in-progress scan.
- mux_out  input  1  bit returned by the mux for the current `select`.
- select  output  SEL_W  channel index driven to the mux.
- busy  output  1  high from the start edge until the scan completes or aborts.
- done  output  1  one-cycle pulse: `sample_word` newly valid.
- sample_word  output  NUM_CH  reconstructed word; bit i = `mux_out` sampled with `select` = i.
- parity  output  1  present only with SCAN_PARITY_EN.

Behaviour:
- Reset (`rst_n` = 0, asynchronous): state = IDLE; `select` = 0; `busy` = 0; `done` = 0; `sample_word` = 0; `parity` = 0; shadow register and settle counter = 0. Reset mid-scan discards all partial data.
- Outputs: all registered; no combinational path from inputs to outputs.
- IDLE:
  - `start` = 1 at edge k: state → SETTLE, `select` = 0, counter = SETTLE_CYCLES, `busy` = 1.
  - `start` is ignored in all other states.
- SETTLE: counter decrements each cycle. At the edge where the counter reaches 0, state → SAMPLE.
- SAMPLE (one cycle): `shadow[select]` ← `mux_out`.
  - If `select` < NUM_CH-1: `select` increments, counter reloads, state → SETTLE.
  - If `select` = NUM_CH-1:
    - `sample_word` ← {`mux_out`, shadow[NUM_CH-2:0]}.
    - `done` ← 1, `busy` ← 0, `select` ← 0, state → IDLE.
- Timing:
  - Channel i is captured at edge k + (i+1)·(SETTLE_CYCLES+1).
  - `done` rises at edge k + NUM_CH·(SETTLE_CYCLES+1), i.e. edge k+48 for the defaults.
- `done`:
  - Exactly one cycle wide.
  - `sample_word` updates only on that edge and holds until the next completed scan.
  - `start` in the cycle `done` is high is accepted, since state is already IDLE; `done` still falls next cycle.
- `abort` = 1 in SETTLE or SAMPLE:
  - State → IDLE, `select` → 0, `busy` → 0.
  - No `done`; `sample_word` unchanged; shadow contents discarded.
  - `abort` in IDLE has no effect. `abort` takes priority over a SAMPLE capture in the same cycle.
- `select` never exceeds NUM_CH-1; there is no wrap-around into a second pass.
- `mux_out` is assumed combinationally derived from `select`. SETTLE_CYCLES covers the mux propagation and any pipeline registers.

Optional Feature:
- Macro: SCAN_PARITY_EN.
- Defined:
  - `parity` port exists.
  - On the completion edge, `parity` ← XOR of the new `sample_word`; it holds with `sample_word`.
  - Reset value 0; unaffected by abort.
- Undefined: no `parity` port and no XOR logic; all other behaviour identical.

Decomposition:
- Package `mux_scan_pkg`:
  - State enum (IDLE, SETTLE, SAMPLE).
  - Default constants NUM_CH = 16, SEL_W = 4, SETTLE_CYCLES = 2.
  - Counter width derived as $clog2(SETTLE_CYCLES+1).
- Sub-module `scan_settle_timer`:
  - Loadable down-counter with `load`, `clear` and a `zero` flag.
  - Instantiated once; `clear` is driven by abort/reset.

Test Plan:
- Reset, then release with no `start` → `select` = 0, `busy` = 0, `done` = 0, `sample_word` = 16'h0000 held indefinitely.
- Bench models the mux with `data` = 16'hA5C3, pulse `start` → `done` high at edge 48 for exactly one cycle, `sample_word` = 16'hA5C3, `busy` low after; with SCAN_PARITY_EN, `parity` = 0.
- Repeat with `data` = 16'h0001 → `sample_word` = 16'h0001, `parity` = 1. Also `start` held high through the scan → exactly one scan, then a second begins the cycle `done` is high.
- Assert `abort` when `select` = 7 → `busy` drops next edge, no `done`, `sample_word` keeps the previous 16'hA5C3, `select` = 0.
- Drop `rst_n` asynchronously mid-SETTLE at `select` = 10 → all outputs 0 immediately (no clock needed); a new `start` gives a correct full scan.
- SETTLE_CYCLES = 1 build: `select` steps every 2 cycles and `done` rises at edge 32. A bench mux with a 1-cycle registered output still yields the correct word.
